// File: rtl/adc_pkg.sv
// Shared constants and state encoding for the serial ADC read controller.
package adc_pkg;

  localparam int DATA_W     = 12;
  localparam int LEAD_BITS  = 4;
  localparam int CH_W       = 3;
  localparam int SETUP_CYC  = 2;
  localparam int RELAX_TIME = 36;

  localparam int FRAME_BITS = LEAD_BITS + DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    RELAX = 2'd3
  } state_t;

endpackage

// File: rtl/read_adc_if.sv
// Host-side bundle of read_adc: toggle request/completion, channel select, and held result.
interface read_adc_if;
  import adc_pkg::*;

  logic              start;
  logic [CH_W-1:0]   channel;
  logic              finish;
  logic [DATA_W-1:0] data;

  modport master (
    output start,
    output channel,
    input  finish,
    input  data
  );

  modport slave (
    input  start,
    input  channel,
    output finish,
    output data
  );

endinterface

// File: rtl/adc_sclk_gen.sv
// Serial clock generator: two clk per bit (low phase, then high phase) while enabled,
// with the frame bit counter and a flag marking the high phase of the final bit.
module adc_sclk_gen
  import adc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic sclk_o,
  output logic phase_o,
  output logic last_bit_o
);

  localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  logic             phase_q, phase_d;
  logic             sclk_q, sclk_d;
  logic [BIT_W-1:0] bit_q, bit_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= 1'b0;
      sclk_q  <= 1'b1;
      bit_q   <= '0;
    end else begin
      phase_q <= phase_d;
      sclk_q  <= sclk_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    phase_d = 1'b0;
    sclk_d  = 1'b1;
    bit_d   = '0;
    if (en_i) begin
      // sclk follows the phase: low on phase 0, high on phase 1.
      phase_d = ~phase_q;
      sclk_d  = phase_q;
      bit_d   = phase_q ? bit_q + BIT_W'(1) : bit_q;
    end
  end

  assign sclk_o     = sclk_q;
  assign phase_o    = phase_q;
  assign last_bit_o = en_i & phase_q & (bit_q == BIT_W'(FRAME_BITS - 1));

endmodule

// File: rtl/read_adc.sv
// Serial ADC read controller: one framed read per start/finish toggle request,
// channel select shifted out on adc_din, result shifted in from adc_dout and held on data.
module read_adc
  import adc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  read_adc_if.slave  host,
  output logic       cs_n,
  output logic       sclk,
  output logic       adc_din,
  input  logic       adc_dout
);

  localparam int WAIT_MAX = (SETUP_CYC > RELAX_TIME) ? SETUP_CYC : RELAX_TIME;
  localparam int CNT_W    = $clog2(WAIT_MAX + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   ch_sr_q, ch_sr_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              cs_n_q, cs_n_d;
  logic              din_q, din_d;
  logic              finish_q, finish_d;

  logic shift_en;
  logic phase;
  logic last_bit;
  logic pending;

  assign shift_en = (state_q == SHIFT);
  assign pending  = host.start ^ finish_q;

  adc_sclk_gen u_sclk_gen (
    .clk        (clk),
    .rst        (rst),
    .en_i       (shift_en),
    .sclk_o     (sclk),
    .phase_o    (phase),
    .last_bit_o (last_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ch_sr_q  <= '0;
      shreg_q  <= '0;
      data_q   <= '0;
      cs_n_q   <= 1'b1;
      din_q    <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ch_sr_q  <= ch_sr_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      cs_n_q   <= cs_n_d;
      din_q    <= din_d;
      finish_q <= finish_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ch_sr_d  = ch_sr_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    cs_n_d   = cs_n_q;
    din_d    = din_q;
    finish_d = finish_q;

    unique case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        din_d  = 1'b0;
        if (pending) begin
          // Channel MSB goes out with cs_n; the rest waits in ch_sr_q, zero-filled behind.
          state_d = SETUP;
          cs_n_d  = 1'b0;
          din_d   = host.channel[CH_W-1];
          ch_sr_d = host.channel << 1;
          cnt_d   = '0;
        end
      end

      SETUP: begin
        if (cnt_q == CNT_W'(SETUP_CYC)) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      SHIFT: begin
        if (!phase) begin
          din_d   = ch_sr_q[CH_W-1];
          ch_sr_d = ch_sr_q << 1;
        end else begin
          shreg_d = {shreg_q[DATA_W-2:0], adc_dout};
          if (last_bit) begin
            state_d = RELAX;
            cs_n_d  = 1'b1;
            din_d   = 1'b0;
            cnt_d   = '0;
          end
        end
      end

      RELAX: begin
        if (cnt_q == CNT_W'(RELAX_TIME - 1)) begin
          state_d  = IDLE;
          data_d   = shreg_q;
          finish_d = ~finish_q;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign cs_n        = cs_n_q;
  assign adc_din     = din_q;
  assign host.finish = finish_q;
  assign host.data   = data_q;

endmodule

// File: tb/tb_read_adc.sv
// Self-checking bench for read_adc: serial ADC model, vector table, busy-toggle and reset sequences, random reads.
`timescale 1ns/1ps
module tb_read_adc;

  logic clk = 1'b0;
  logic rst;
  logic cs_n, sclk, adc_din, adc_dout;

  read_adc_if host_if ();

  read_adc dut (
    .clk      (clk),
    .rst      (rst),
    .host     (host_if.slave),
    .cs_n     (cs_n),
    .sclk     (sclk),
    .adc_din  (adc_din),
    .adc_dout (adc_dout)
  );

  always #5 clk = ~clk;

  localparam int EXP_LAT = 71;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // ADC model and bus observer state
  logic [15:0] frame_q[$];
  logic [15:0] cur_frame;
  int          bit_idx, rises, falls, frames, cs_low_cycles;
  logic [2:0]  din_bits;
  logic        prev_sclk = 1'b1, prev_cs_n = 1'b1, prev_din = 1'b0;

  typedef struct {
    logic [2:0]  ch;
    logic [15:0] frame;
    logic [11:0] exp_data;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock, sampled 1ns after the rising edge; the ADC model reacts to what it sees.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (prev_cs_n && !cs_n) begin
      frames++;
      rises    = 0;
      falls    = 0;
      bit_idx  = 0;
      din_bits = '0;
      cur_frame = (frame_q.size() > 0) ? frame_q.pop_front() : 16'h0000;
    end
    if (!cs_n) cs_low_cycles++;
    if (prev_sclk && !sclk && !cs_n) begin
      if (falls < 3) din_bits[2-falls] = prev_din;
      falls++;
      adc_dout = (bit_idx < 16) ? cur_frame[15-bit_idx] : 1'b0;
      bit_idx++;
    end
    if (!prev_sclk && sclk && !prev_cs_n) rises++;
    prev_sclk = sclk;
    prev_cs_n = cs_n;
    prev_din  = adc_din;
  endtask

  task automatic wait_finish(input int t0, output int lat);
    logic f0;
    f0  = host_if.finish;
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (host_if.finish !== f0) begin
        lat = cyc - t0 - 1;
        break;
      end
    end
  endtask

  task automatic run_read(input logic [2:0] ch, input logic [15:0] fr, output int lat);
    int t0;
    frame_q.push_back(fr);
    host_if.channel = ch;
    host_if.start   = ~host_if.start;
    t0 = cyc;
    wait_finish(t0, lat);
  endtask

  // Read with ntog extra start toggles while busy; odd counts owe one more read.
  task automatic multi_read(input logic [2:0] ch, input logic [2:0] ch2, input int ntog,
                            input logic [15:0] f1, input logic [15:0] f2);
    int nexp, f0;
    nexp = 1 + (ntog % 2);
    f0   = frames;
    frame_q.push_back(f1);
    if (nexp == 2) frame_q.push_back(f2);
    host_if.channel = ch;
    host_if.start   = ~host_if.start;
    repeat (3) step();
    host_if.channel = ch2;
    for (int k = 0; k < ntog; k++) begin
      repeat (6) step();
      host_if.start = ~host_if.start;
    end
    repeat (300) step();
    check("frame_count", frames - f0, nexp);
    check("finish_eq_start", host_if.finish, host_if.start);
    check("multi_data", host_if.data, {20'h0, ((nexp == 2) ? f2[11:0] : f1[11:0])});
    check("multi_channel_bits", din_bits, (nexp == 2) ? ch2 : ch);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2, t0;

    tbl[0] = '{ch: 3'd5, frame: 16'h0A5C, exp_data: 12'hA5C};
    tbl[1] = '{ch: 3'd0, frame: 16'hF123, exp_data: 12'h123};
    tbl[2] = '{ch: 3'd7, frame: 16'h8000, exp_data: 12'h000};
    tbl[3] = '{ch: 3'd2, frame: 16'h7FFF, exp_data: 12'hFFF};

    rst = 1'b1;
    host_if.start   = 1'b0;
    host_if.channel = 3'd0;
    adc_dout = 1'b0;
    frames = 0;
    repeat (3) step();
    rst = 1'b0;

    check("rst_finish", host_if.finish, 1'b0);
    check("rst_data", host_if.data, 12'h000);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_sclk", sclk, 1'b1);
    check("rst_adc_din", adc_din, 1'b0);
    cs_low_cycles = 0;
    repeat (100) step();
    check("idle_no_cs_activity", cs_low_cycles, 0);

    foreach (tbl[i]) begin
      run_read(tbl[i].ch, tbl[i].frame, lat);
      check("read_latency", lat, EXP_LAT);
      check("read_data", host_if.data, tbl[i].exp_data);
      check("read_finish_eq_start", host_if.finish, host_if.start);
      check("read_sclk_rises", rises, 16);
      check("read_channel_bits", din_bits, tbl[i].ch);
      check("read_cs_n_released", cs_n, 1'b1);
      repeat (5) step();
    end

    // Back-to-back: second request raised on the cycle after finish toggles.
    frame_q.push_back(16'h0FFF);
    frame_q.push_back(16'h0001);
    host_if.channel = 3'd1;
    host_if.start   = ~host_if.start;
    t0 = cyc;
    wait_finish(t0, lat);
    check("b2b_lat1", lat, 71);
    check("b2b_data1", host_if.data, 12'hFFF);
    host_if.start = ~host_if.start;
    wait_finish(t0, lat2);
    check("b2b_lat2", lat2, 143);
    check("b2b_data2", host_if.data, 12'h001);
    repeat (5) step();

    multi_read(3'd4, 3'd4, 2, 16'hC0DE, 16'h0000);
    multi_read(3'd3, 3'd6, 3, 16'h1357, 16'h2468);

    for (int r = 0; r < 12; r++) begin
      logic [2:0]  ch, ch2;
      logic [15:0] f1, f2;
      ch  = 3'($urandom_range(0, 7));
      ch2 = 3'($urandom_range(0, 7));
      f1  = 16'($urandom);
      f2  = 16'($urandom);
      multi_read(ch, ch2, $urandom_range(0, 3), f1, f2);
    end

    // Reset in the middle of bit 7, while sclk is low.
    frame_q.push_back(16'hBEEF);
    host_if.channel = 3'd6;
    host_if.start   = ~host_if.start;
    for (int i = 0; i < 100; i++) begin
      step();
      if (rises == 7) break;
    end
    check("pre_rst_rises", rises, 7);
    step();
    check("pre_rst_sclk_low", sclk, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_cs_n", cs_n, 1'b1);
    check("mid_rst_sclk", sclk, 1'b1);
    check("mid_rst_data", host_if.data, 12'h000);
    check("mid_rst_finish", host_if.finish, 1'b0);
    host_if.start = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    frame_q.push_back(16'h7AB3);
    t0 = cyc;
    wait_finish(t0, lat);
    check("post_rst_latency", lat, EXP_LAT);
    check("post_rst_data", host_if.data, 12'hAB3);
    check("post_rst_finish", host_if.finish, 1'b1);
    check("post_rst_rises", rises, 16);
    check("post_rst_channel_bits", din_bits, 3'd6);
    repeat (10) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/read_adc.md
Name: read_adc

Overview:
- Serial ADC read controller; the input-side counterpart of the board's serial DAC write path.
- Runs one framed read per request on a toggle handshake (start/finish):
  - drives the converter's frame-select (cs_n), serial clock (sclk) and channel-select line (adc_din);
  - shifts the conversion result in from adc_dout.
- Holds the last result on data for the measurement and control logic.

Parameters:
DATA_W, 12, result width in bits
LEAD_BITS, 4, leading frame bits, discarded
CH_W, 3, channel-select width, sent MSB-first at the start of the frame
SETUP_CYC, 2, clk cycles with cs_n low before the first sclk fall
RELAX_TIME, 36, clk cycles with cs_n high after the frame, before completion

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  request toggle; a read is pending whenever start != finish
channel  in  CH_W  ADC channel; sampled on the edge that leaves IDLE
finish  out  1  completion toggle; equals start after the read completes
data  out  DATA_W  last conversion result; changes only on the edge that toggles finish
cs_n  out  1  ADC frame select, active-low
sclk  out  1  ADC serial clock, idles high, period = 2 clk
adc_din  out  1  channel-select bits to the ADC
adc_dout  in  1  serial data from the ADC, MSB first

Behaviour:
- Reset (async, rst=1), all outputs and state:
  - finish=0, data=0, cs_n=1, sclk=1, adc_din=0;
  - state=IDLE, all counters=0, shift register=0.
- FRAME_BITS = LEAD_BITS+DATA_W (16). All outputs are registered.
- States: IDLE, SETUP, SHIFT, RELAX.
- IDLE:
  - cs_n=1, sclk=1, adc_din=0.
  - If start^finish at a clk edge: go to SETUP, cs_n<=0, latch channel, adc_din<=channel MSB.
- SETUP:
  - Count SETUP_CYC cycles, then enter SHIFT with phase=0 and bit=0.
- SHIFT, two clk per bit:
  - phase 0: sclk<=0; adc_din<=next channel bit, or 0 once CH_W bits have been sent.
  - phase 1: sclk<=1; shift_reg<={shift_reg,adc_dout}. adc_dout is sampled at the clk edge that raises sclk, one clk after the fall.
  - After the phase-1 sample of bit FRAME_BITS-1: cs_n<=1, sclk stays 1, adc_din<=0, go to RELAX.
- RELAX:
  - Count RELAX_TIME cycles.
  - On the last one: data<=shift_reg[DATA_W-1:0], finish<=~finish, go to IDLE.
- Latency:
  - Edge 0 is the first edge with start^finish=1.
  - finish toggles at edge 1+SETUP_CYC+2*FRAME_BITS+RELAX_TIME, i.e. 71 with defaults.
- Leading bits: the first LEAD_BITS sampled bits are discarded regardless of value.
- start changes while busy:
  - Ignored until completion.
  - A pending request is re-evaluated in IDLE on the cycle after finish toggles.
  - So an odd number of toggles during a read yields exactly one further read; an even number yields none.
- channel changes while busy: no effect on the current frame.
- Reset mid-frame:
  - Immediate abort: cs_n=1, sclk=1, finish=0, data=0.
  - After release, a read starts at once if start=1.

Decomposition:
- Shared package adc_pkg: state enum (IDLE, SETUP, SHIFT, RELAX), default DATA_W, LEAD_BITS, CH_W, SETUP_CYC, RELAX_TIME, and the derived FRAME_BITS.
- One natural sub-module: adc_sclk_gen, the phase toggle generating sclk plus the bit counter and its last-bit flag.
- Shift register and FSM stay in read_adc.

Test Plan:
- Reset: rst=1 with start=0, then release → finish=0, data=0x000, cs_n=1, sclk=1, adc_din=0; no cs_n activity for 100 cycles.
- Single read: ADC model returns frame 0x0A5C, channel=5, start toggled 0→1 →
  - adc_din carries 1,0,1 on the first three sclk falls;
  - 16 sclk rising edges while cs_n=0;
  - data=0xA5C and finish=1 on edge 71.
- Leading-bit discard: model frame 0xF123 → data=0x123.
- Back-to-back: start toggled again on the cycle after finish toggles; model returns 0x0FFF, then 0x0001 → two frames; data=0xFFF, then 0x001; finish toggles at edges 71 and 143 (the second read starts on edge 72).
- Busy toggles:
  - start toggled twice during a read → exactly one frame; finish==start afterwards.
  - Toggled three times → two frames.
- Reset mid-frame: rst pulsed during bit 7 of SHIFT →
  - cs_n=1 and sclk=1 asynchronously; data=0, finish=0.
  - With start=1 at release, a fresh full frame follows and completes normally.
